// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the state type of the memory slave FSM.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    WRESP = 2'd3
  } axi_mem_state_e;

  // Severity order DECERR > SLVERR > OKAY matches the numeric order of the
  // codes; EXOKAY is never produced by this slave, so a plain max suffices.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for an AXI burst (FIXED / INCR / WRAP, reserved as INCR).
// Latency: purely combinational.
// Backpressure: none; caller registers the result only on a data handshake.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_wrap_mask;
  logic                  w_wrap_ok;

  // Step by 1<<size; WRAP keeps the upper bits of the (len+1)*step window
  always_comb begin
    w_step      = ADDR_WIDTH'(1) << i_size;
    w_incr      = i_addr + w_step;
    w_wrap_ok   = (i_burst == BURST_WRAP) &&
                  ((i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15));
    w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
    if (i_burst == BURST_FIXED) begin
      o_next_addr = i_addr;
    end else if (w_wrap_ok) begin
      o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
    end else begin
      o_next_addr = w_incr;
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 slave serving one burst at a time from an internal word memory.
// Latency: AR/AW accept in IDLE, first R beat / wready the next cycle, B the cycle after last W.
// Backpressure: per-beat on R (held while rready low), W (wready only in WR) and B (held until bready).
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    MEM_WORDS  = 65536,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1c00_0000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready
);

  localparam int                    IDX_W     = $clog2(MEM_WORDS);
  localparam int                    STRB_W    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * 4);

  axi_mem_state_e        r_state;
  axi_mem_state_e        w_state_nxt;
  logic                  r_last_was_rd;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_beat_cnt;
  logic [1:0]            r_bresp;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_last_beat;
  logic [1:0]            w_beat_resp;
  logic [1:0]            w_wlast_resp;
  logic                  w_rd_pick;
  logic                  w_ar_hs;
  logic                  w_aw_hs;
  logic                  w_r_hs;
  logic                  w_w_hs;

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  // Decode the current beat: word index, range check and per-beat response
  always_comb begin
    w_off       = r_addr - BASE_ADDR;
    w_in_range  = (r_addr >= BASE_ADDR) && (w_off < MEM_BYTES);
    w_idx       = w_off[IDX_W+1:2];
    w_last_beat = (r_beat_cnt == r_len);
    if (!w_in_range) begin
      w_beat_resp = RESP_DECERR;
    end else if (r_size > 3'd2) begin
      w_beat_resp = RESP_SLVERR;
    end else begin
      w_beat_resp = RESP_OKAY;
    end
    // The beat counter is authoritative; a wlast that disagrees taints bresp
    w_wlast_resp = (i_wlast != w_last_beat) ? RESP_SLVERR : RESP_OKAY;
  end

  // Arbitration, next state and all channel outputs (zero outside their state)
  always_comb begin
    w_state_nxt = r_state;
    o_arready   = 1'b0;
    o_awready   = 1'b0;
    o_rvalid    = 1'b0;
    o_rlast     = 1'b0;
    o_rdata     = '0;
    o_rid       = '0;
    o_rresp     = RESP_OKAY;
    o_wready    = 1'b0;
    o_bvalid    = 1'b0;
    o_bid       = '0;
    o_bresp     = RESP_OKAY;
    // On a tie, serve whichever channel was not served last
    w_rd_pick   = i_arvalid && (!i_awvalid || !r_last_was_rd);
    case (r_state)
      IDLE: begin
        o_arready = w_rd_pick && !i_rst;
        o_awready = i_awvalid && !w_rd_pick && !i_rst;
        if (o_arready) begin
          w_state_nxt = RD;
        end else if (o_awready) begin
          w_state_nxt = WR;
        end
      end
      RD: begin
        o_rvalid = 1'b1;
        o_rlast  = w_last_beat;
        o_rdata  = w_in_range ? r_mem[w_idx] : '0;
        o_rid    = r_id;
        o_rresp  = w_beat_resp;
        if (i_rready && w_last_beat) begin
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        o_wready = !i_rst;
        if (i_wvalid && o_wready && w_last_beat) begin
          w_state_nxt = WRESP;
        end
      end
      WRESP: begin
        o_bvalid = 1'b1;
        o_bid    = r_id;
        o_bresp  = r_bresp;
        if (i_bready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ar_hs = o_arready && i_arvalid;
  assign w_aw_hs = o_awready && i_awvalid;
  assign w_r_hs  = o_rvalid && i_rready;
  assign w_w_hs  = o_wready && i_wvalid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch burst parameters on accept, then step address/count per data beat
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_was_rd <= 1'b0;
      r_addr        <= '0;
      r_id          <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_beat_cnt    <= '0;
      r_bresp       <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_last_was_rd <= 1'b1;
        r_addr        <= i_araddr;
        r_id          <= i_arid;
        r_len         <= i_arlen;
        r_size        <= i_arsize;
        r_burst       <= i_arburst;
        r_beat_cnt    <= '0;
      end else if (w_aw_hs) begin
        r_last_was_rd <= 1'b0;
        r_addr        <= i_awaddr;
        r_id          <= i_awid;
        r_len         <= i_awlen;
        r_size        <= i_awsize;
        r_burst       <= i_awburst;
        r_beat_cnt    <= '0;
        r_bresp       <= RESP_OKAY;
      end else if (w_r_hs || w_w_hs) begin
        r_addr     <= w_next_addr;
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      if (w_w_hs) begin
        r_bresp <= resp_worst(r_bresp, resp_worst(w_beat_resp, w_wlast_resp));
      end
    end
  end

  // Byte-enable write port; contents deliberately survive reset
  always_ff @(posedge i_clk) begin
    if (w_w_hs && w_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

AXI4 slave responder that terminates the core's AXI master port (`mem_bus`) in simulation and FPGA bring-up builds. It serves the burst read and write traffic issued by the I/D cache path from an internal word-addressed memory array. Its handshake and burst behaviour stand in for the SoC memory controller. One transaction is in flight at a time, with read/write arbitration and full per-beat backpressure on every channel.

## Interface
- `ADDR_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 32, AXI data width; only 32 is supported
- `ID_WIDTH`, 4, AXI ID width
- `MEM_WORDS`, 65536, memory depth in 32-bit words; must be a power of two
- `BASE_ADDR`, 32'h1c00_0000, byte address of word 0
- `clk`  in  1  clock; the block has one clock
- `rst`  in  1  reset, synchronous, active-high
- `araddr/arid/arlen/arsize/arburst`  in  32/4/8/3/2  read address channel
- `arvalid` in 1; `arready` out 1
- `rdata/rid/rresp`  out  32/4/2  read data channel
- `rlast`, `rvalid` out 1 each; `rready` in 1
- `awaddr/awid/awlen/awsize/awburst`  in  32/4/8/3/2  write address channel
- `awvalid` in 1; `awready` out 1
- `wdata/wstrb`  in  32/4  write data channel
- `wlast`, `wvalid` in 1 each; `wready` out 1
- `bid/bresp`  out  4/2  write response channel
- `bvalid` out 1; `bready` in 1

## Operation
- FSM states: IDLE, RD, WR, WRESP. Next state is registered.
- IDLE, arbitration:
  - When both `arvalid` and `awvalid` are high, grant goes to the channel not served last (`last_was_rd` flag; its reset value is 0, so read wins first).
  - `arready`/`awready` is high only in IDLE, and only for the granted channel.
- AR accepted: latch id, len, size, burst and the beat address; set `beat_cnt`=0; go to RD.
- RD:
  - Drive `rdata` = mem[word(addr)], `rlast` = (`beat_cnt`==len), `rresp`.
  - On `rvalid&&rready`: advance the address and increment `beat_cnt`. On the last beat, return to IDLE.
- AW accepted: latch the same fields; go to WR.
- WR:
  - `wready`=1. On each W handshake, write bytes selected by `wstrb` if the address is in range, then advance.
  - On the beat where `beat_cnt`==len, go to WRESP.
- WRESP: `bvalid`=1; `bid` is the latched id. On `bready`, return to IDLE.
- Address generation, with step = 1<<size:
  - FIXED (00): address does not change.
  - INCR (01): address += step.
  - WRAP (10): address increments within a (len+1)*step-aligned window. Legal len for WRAP is 1, 3, 7 or 15; any other len is treated as INCR.
  - Reserved (11): treated as INCR.
- Response codes:
  - Out of range (address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS)): DECERR (2'b11). Reads return 0 and writes are dropped.
  - `arsize`/`awsize` > 2: SLVERR (2'b10) on every beat.
  - Otherwise OKAY.
  - `bresp` is the worst code seen over all beats, ordered DECERR > SLVERR > OKAY.
- `wlast` mismatch: `beat_cnt` is authoritative. If `wlast` disagrees with (`beat_cnt`==len) on any beat, `bresp` is at least SLVERR.
- Memory contents are not reset. An optional `$readmemh` init file is plusarg-selected.

## Timing
- Reset values: all `*ready`, `rvalid`, `bvalid` and `rlast` are 0; `rdata`/`rid`/`rresp`/`bid`/`bresp` are 0; state is IDLE.
- Read: AR handshake in cycle N gives `rvalid` in N+1. With `rready` held high, one beat per cycle; a len=7 burst completes in N+8.
- Read backpressure: `rvalid`/`rdata`/`rlast`/`rresp` stay stable while `rready`=0.
- Write: AW handshake in cycle N gives `wready` from N+1. The last W handshake in cycle M gives `bvalid` in M+1.
- Back-to-back transactions: the earliest next `arready`/`awready` is the cycle after the final R or B handshake, which costs one IDLE bubble.
- W beats arriving before AW: not accepted (`wready`=0 outside WR).
- `rst` asserted mid-burst: the next cycle is IDLE with all outputs at reset values. The partial burst is abandoned, and bytes already written stay written.
- Read-after-write to the same address: a later read sees the new data.

## Structure
- Constants and typedefs live in the shared `axi_pkg`:
  - `BURST_FIXED/INCR/WRAP`
  - `RESP_OKAY/EXOKAY/SLVERR/DECERR`
  - the `axi_mem_state_e` enum
- Sub-module `axi_burst_addr_gen`: combinational next-address calculation from (addr, len, size, burst). It is shared by the read and write paths.
- Memory is a plain `logic [31:0] mem[MEM_WORDS]` with byte-enable writes, inferring BRAM/LUTRAM.

## Test plan
- Preload mem[0..7]=0x100..0x107; AR addr=BASE_ADDR, len=7, INCR, size=2, `rready`=1 -> 8 beats 0x100..0x107 in consecutive cycles, `rlast` on beat 8, `rresp`=0, `rid` echoed.
- AR WRAP len=3 at BASE_ADDR+0x8 -> data order words 2,3,0,1; `rready` toggled every other cycle -> data held stable while stalled.
- AW INCR len=1 at BASE_ADDR+0x10 with wstrb 4'b0011 then 4'b1111, wdata 0xAABBCCDD twice, over prior contents 0x11111111 -> mem[4]=0x1111CCDD, mem[5]=0xAABBCCDD, `bresp`=OKAY, `bvalid` held until `bready`.
- Simultaneous `arvalid`/`awvalid` after reset, repeated 3 times -> grant order R, W, R.
- AR to address 0x0 -> `rresp`=DECERR, `rdata`=0. AW with `wlast` early on a len=3 burst -> `bresp`=SLVERR, 4 beats still accepted.
- `rst` pulsed during beat 3 of a len=7 read -> next cycle `rvalid`=0 and `arready`=1; the new AR is serviced normally.
